pll_cfg_seq: RTL
================

// Module: pll_cfg_seq
// PURPOSE
//  Sequences run-time reprogramming of the fractional system PLL between NTSC and PAL clock sets.
//  Sits in the clk domain beside the PLL and its altera_pll_reconfig block.
//  Detects a change of the requested video standard and issues the Avalon-MM register writes to
//  the reconfig block: mode, M, M-fraction, C0, C1, start. Then waits for PLL relock.
//  Reports busy, done and lock-timeout status to the core.
// PARAMETERS
//  M_NTSC     32'h0000_0808  raw M-counter register word, NTSC set
//  K_NTSC     32'h5A1C_AC08  raw M-fraction (K) word, NTSC set
//  C0_NTSC    32'h0000_0404  raw C0 word (counter select in [22:18] = 0), NTSC set
//  C1_NTSC    32'h0004_0808  raw C1 word (counter select = 1), NTSC set
//  M_PAL / K_PAL / C0_PAL / C1_PAL  same four words, PAL set
//  SETTLE     16             cycles after start write during which locked is ignored
//  LOCK_TMO   1_000_000      cycles allowed for relock (timeout feature only)
// PORTS
//  clk             in   1   reconfig/management clock (50 MHz reference domain)
//  rst_n           in   1   asynchronous active-low reset
//  pal             in   1   requested standard, 1=PAL 0=NTSC; asynchronous, 2-FF synchronised inside
//  pll_locked      in   1   PLL locked, asynchronous, 2-FF synchronised inside
//  cfg_waitrequest in   1   Avalon-MM waitrequest from reconfig block
//  cfg_write       out  1   Avalon-MM write strobe
//  cfg_address     out  6   Avalon-MM word address
//  cfg_writedata   out  32  Avalon-MM write data
//  busy            out  1   high from sequence start until relock or timeout
//  done            out  1   one-cycle pulse on successful relock
//  mode_active     out  1   standard currently programmed (1=PAL)
//  lock_err        out  1   sticky timeout flag; cleared when the next sequence starts
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, mode_active=0. The PLL power-up image is treated as NTSC.
//  Request: in IDLE, when pal_sync != mode_active, latch target=pal_sync and enter WR_MODE next cycle.
//   - A pal_sync of 1 at reset release therefore starts a sequence immediately after reset.
//  Write states, in order, with address and data:
//   - WR_MODE    addr 0  data 0 (waitrequest mode)
//   - WR_M       addr 4  M word
//   - WR_K       addr 7  K word
//   - WR_C0      addr 5  C0 word
//   - WR_C1      addr 5  C1 word
//   - WR_START   addr 2  data 1
//  Write handshake:
//   - cfg_write=1 with address/data held stable for the whole state.
//   - Write completes on the cycle with cfg_write & !cfg_waitrequest.
//   - The next state is entered on the following edge. cfg_write drops for exactly 1 cycle between writes.
//  Words are selected from the latched target, never from live pal.
//  SETTLE: count SETTLE cycles and ignore pll_locked. Then go to WAIT_LOCK.
//  WAIT_LOCK: first cycle with locked_sync=1 -> mode_active=target, done=1 for 1 cycle, busy=0, IDLE.
//  busy: 1 from the WR_MODE entry cycle through the cycle done is issued.
//  pal changes mid-sequence: ignored until IDLE. The IDLE compare then reruns on the new value.
//   - No write is aborted.
//  Back-to-back: done and the next WR_MODE entry are never in the same cycle (IDLE lasts >=1 cycle).
//  Reset asserted mid-sequence: immediate return to reset state, cfg_write=0 asynchronously.
//   - The PLL may be left half-programmed. The post-reset compare reprograms it if pal_sync=1.
//  Latency with no waitrequest: request detect to first cfg_write = 1 cycle; 6 writes = 11 cycles; then SETTLE.
// CONFIGURATION
//  PLL_CFG_LOCK_TMO_EN defined:
//   - A 20-bit counter runs in WAIT_LOCK.
//   - At LOCK_TMO cycles without lock: lock_err=1, busy=0, no done, mode_active unchanged, IDLE.
//   - The pending mismatch then triggers a retry.
//  Not defined: WAIT_LOCK waits indefinitely, lock_err is tied 0, and no counter is built.
// TESTING
//  1) Reset with pal=0, locked=1 -> no cfg_write for 1000 cycles; busy=0, mode_active=0.
//  2) pal 0->1, waitrequest=0 -> writes (0,0),(4,M_PAL),(7,K_PAL),(5,C0_PAL),(5,C1_PAL),(2,1);
//     locked 0 then 1 at cycle 40 -> done pulse, mode_active=1.
//  3) waitrequest held high 5 cycles on WR_K -> address 7 and data stable for 6 cycles; single write accepted.
//  4) pal toggles 1->0 during WR_C0 -> PAL sequence completes, then an NTSC sequence starts with M_NTSC.
//  5) PLL_CFG_LOCK_TMO_EN with LOCK_TMO=100, locked stuck 0 -> lock_err=1 at cycle 100 after SETTLE;
//     retry restarts at addr 0.
//  6) rst_n low during WR_M -> cfg_write=0 and busy=0 at once; after release, pal=1 reruns the full sequence.

Source files
------------

// File: rtl/pll_cfg_seq.sv
// rtl/pll_cfg_seq.sv - NTSC/PAL PLL reprogramming sequencer driving the reconfig block over Avalon-MM.
// Optional relock timeout is built when PLL_CFG_LOCK_TMO_EN is defined.
module pll_cfg_seq #(
  parameter logic [31:0] M_NTSC   = 32'h0000_0808,
  parameter logic [31:0] K_NTSC   = 32'h5A1C_AC08,
  parameter logic [31:0] C0_NTSC  = 32'h0000_0404,
  parameter logic [31:0] C1_NTSC  = 32'h0004_0808,
  parameter logic [31:0] M_PAL    = 32'h0000_0707,
  parameter logic [31:0] K_PAL    = 32'h2E8B_A2E9,
  parameter logic [31:0] C0_PAL   = 32'h0000_0303,
  parameter logic [31:0] C1_PAL   = 32'h0004_0707,
  parameter int          SETTLE   = 16,
  parameter int          LOCK_TMO = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pal,
  input  logic        pll_locked,
  input  logic        cfg_waitrequest,
  output logic        cfg_write,
  output logic [5:0]  cfg_address,
  output logic [31:0] cfg_writedata,
  output logic        busy,
  output logic        done,
  output logic        mode_active,
  output logic        lock_err
);

  // Write states are consecutive so a completed write advances by +1.
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_MODE   = 4'd1;
  localparam logic [3:0] S_WR_M      = 4'd2;
  localparam logic [3:0] S_WR_K      = 4'd3;
  localparam logic [3:0] S_WR_C0     = 4'd4;
  localparam logic [3:0] S_WR_C1     = 4'd5;
  localparam logic [3:0] S_WR_START  = 4'd6;
  localparam logic [3:0] S_SETTLE    = 4'd7;
  localparam logic [3:0] S_WAIT_LOCK = 4'd8;

  localparam int SW = $clog2(SETTLE + 1);

  logic [3:0]    state_q, state_d;
  logic          gap_q, gap_d;
  logic          target_q, target_d;
  logic          mode_q, mode_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          pal_meta_q, pal_sync_q;
  logic          lock_meta_q, lock_sync_q;
  logic          in_write, accept;

  assign in_write    = (state_q >= S_WR_MODE) && (state_q <= S_WR_START);
  assign cfg_write   = in_write && !gap_q;
  assign accept      = cfg_write && !cfg_waitrequest;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_WAIT_LOCK) && lock_sync_q;
  assign mode_active = mode_q;

`ifdef PLL_CFG_LOCK_TMO_EN
  logic [19:0] tmo_q, tmo_d;
  logic        lock_err_q, lock_err_d;
  logic        tmo_hit;

  assign tmo_d    = (state_q == S_WAIT_LOCK) ? tmo_q + 20'd1 : 20'd0;
  assign tmo_hit  = (state_q == S_WAIT_LOCK) && !lock_sync_q && (tmo_q == 20'(LOCK_TMO - 1));
  assign lock_err = lock_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q      <= '0;
      lock_err_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      lock_err_q <= lock_err_d;
    end
  end

  always_comb begin
    lock_err_d = lock_err_q;
    if (tmo_hit)
      lock_err_d = 1'b1;
    else if (state_q == S_IDLE && state_d == S_WR_MODE)
      lock_err_d = 1'b0;
  end
`else
  localparam int unused_lock_tmo = LOCK_TMO;
  logic          tmo_hit;
  assign tmo_hit  = 1'b0;
  assign lock_err = 1'b0;
`endif

  // Register words always come from the latched target, never from live pal.
  always_comb begin
    cfg_address   = 6'd0;
    cfg_writedata = 32'd0;
    case (state_q)
      S_WR_M: begin
        cfg_address   = 6'd4;
        cfg_writedata = target_q ? M_PAL : M_NTSC;
      end
      S_WR_K: begin
        cfg_address   = 6'd7;
        cfg_writedata = target_q ? K_PAL : K_NTSC;
      end
      S_WR_C0: begin
        cfg_address   = 6'd5;
        cfg_writedata = target_q ? C0_PAL : C0_NTSC;
      end
      S_WR_C1: begin
        cfg_address   = 6'd5;
        cfg_writedata = target_q ? C1_PAL : C1_NTSC;
      end
      S_WR_START: begin
        cfg_address   = 6'd2;
        cfg_writedata = 32'd1;
      end
      default: begin
        cfg_address   = 6'd0;
        cfg_writedata = 32'd0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = 1'b0;
    target_d = target_q;
    mode_d   = mode_q;
    settle_d = '0;
    case (state_q)
      S_IDLE: begin
        if (pal_sync_q != mode_q) begin
          target_d = pal_sync_q;
          state_d  = S_WR_MODE;
        end
      end
      S_WR_MODE, S_WR_M, S_WR_K, S_WR_C0, S_WR_C1, S_WR_START: begin
        if (accept) begin
          state_d = state_q + 4'd1;
          gap_d   = (state_q != S_WR_START);
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE - 1))
          state_d = S_WAIT_LOCK;
        else
          settle_d = settle_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        if (lock_sync_q) begin
          mode_d  = target_q;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_q       <= 1'b0;
      target_q    <= 1'b0;
      mode_q      <= 1'b0;
      settle_q    <= '0;
      pal_meta_q  <= 1'b0;
      pal_sync_q  <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      target_q    <= target_d;
      mode_q      <= mode_d;
      settle_q    <= settle_d;
      pal_meta_q  <= pal;
      pal_sync_q  <= pal_meta_q;
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

endmodule
